if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, selects the next PC from sequential, branch, jump and jump-register sources, and reads the current instruction from a local instruction memory. The debug unit loads that memory and gates PC advance. Outputs feed the IF/ID pipeline register.

## Interface
- NB_REG, 32, data/PC/instruction width
- NB_WIDHT, 9, instruction-memory byte-address width (2^9 = 512 bytes = 128 words)
- NB_INST, 26, jump-target field width
- i_clk  in  1  single clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_dunit_clk_en  in  1  debug-unit step/run enable for the PC
- i_dunit_w_en  in  1  instruction-memory write enable
- i_dunit_addr  in  NB_WIDHT  byte address for memory write
- i_dunit_data  in  NB_REG  word to write
- i_PCSrc  in  1  take branch target
- i_Jump  in  1  take jump (J/JAL or JR/JALR)
- i_JSel  in  1  with jump: 1 = register target, 0 = immediate target
- i_PCWrite  in  1  hazard-unit PC enable (0 = stall)
- i_inmed  in  NB_REG  fully computed branch target address
- i_inst_to_mxp  in  NB_INST  instr[25:0] jump field
- i_pc_jsel  in  NB_REG  register jump target (rs)
- o_pcplus4  out  NB_REG  PC + 4
- o_instruction  out  NB_REG  memory word at current PC

## Operation
- PC register, NB_REG bits. Loads next_pc when i_dunit_clk_en && i_PCWrite; else holds.
- next_pc priority: i_Jump && i_JSel -> i_pc_jsel; i_Jump -> {pcplus4[31:28], i_inst_to_mxp, 2'b00}; i_PCSrc -> i_inmed; else pc + 4.
- i_JSel is ignored when i_Jump = 0.
- o_pcplus4 = pc + 4, modulo 2^32, combinational.
- o_instruction = mem[pc[NB_WIDHT-1:2]], asynchronous read. PC bits above NB_WIDHT-1 and bits [1:0] are ignored, so addresses alias.
- Memory: 2^(NB_WIDHT-2) words.
  - Write occurs on the clock edge when i_dunit_w_en = 1: mem[i_dunit_addr[NB_WIDHT-1:2]] <= i_dunit_data.
  - Writes are independent of i_dunit_clk_en, i_PCWrite and i_reset.

## Timing
- Reset: PC = 0, so o_pcplus4 = 0x00000004 and o_instruction = mem[0] during and after reset.
- Reset has priority over a PC update on the same edge.
- The PC update takes effect one cycle after the select/enable inputs are sampled. The new PC and instruction are visible after that edge with zero further latency.
- Write then read of the same word:
  - Before the write edge, the read returns the old data.
  - After the edge, it returns the new data.
  - There is no bypass.
- Stall (i_PCWrite = 0 or i_dunit_clk_en = 0): PC, o_pcplus4 and o_instruction are stable, unless the currently addressed word is written.
- PC wrap: 0xFFFFFFFC + 4 = 0x00000000.

## Configuration
- IF_MEM_CLEAR_EN:
  - When defined, synchronous reset also clears every memory word to 0. A write on the same edge is overridden.
  - When undefined, memory contents survive reset, so a debug-loaded program is retained.

## Structure
- Shared package if_pkg holds the default widths (NB_REG, NB_WIDHT, NB_INST) and the PC-source select encoding (SEQ, BRANCH, JUMP, JREG).
- One sub-module, if_inst_mem: a parameterized word memory with async read and sync write, plus the optional clear.
- PC register and next-PC mux live in the top level.

## Test plan
- Reset, empty memory: i_reset = 1 for one cycle -> o_pcplus4 = 0x4, o_instruction = mem[0].
- Load and fetch:
  - Write 0xDEADBEEF at addr 0x08 and 0x12345678 at addr 0x0C with i_PCWrite = 0.
  - Then run with i_PCWrite = 1 and no branch -> after 2 edges o_instruction = 0xDEADBEEF; after 3 edges 0x12345678.
- Branch: from PC = 0, i_PCSrc = 1, i_inmed = 0x20 -> after one edge o_pcplus4 = 0x24.
- Jump: i_Jump = 1, i_JSel = 0, i_inst_to_mxp = 26'h2AAAAAA at PC = 0x20 -> next PC = 0x0AAAAAA8; also i_Jump = 1, i_JSel = 1, i_pc_jsel = 0x80 -> o_pcplus4 = 0x84.
- Priority and stall:
  - i_PCSrc = 1 and i_Jump = 1 together -> jump target wins.
  - i_PCWrite = 0 or i_dunit_clk_en = 0 for 3 edges -> o_pcplus4 unchanged.
- Reset mid-run: PC = 0x40, i_reset = 1 -> o_pcplus4 = 0x4 next edge; memory retained, or zeroed with IF_MEM_CLEAR_EN.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared widths and PC-source select encoding for the fetch stage
package if_pkg;
  localparam int NB_REG = 32;
  localparam int NB_WIDHT = 9;
  localparam int NB_INST = 26;
  typedef enum logic [1:0] {SEQ, BRANCH, JUMP, JREG} pc_sel_e;
  function automatic pc_sel_e pc_select(input logic jump, input logic jsel, input logic pcsrc);
    return jump ? (jsel ? JREG : JUMP) : (pcsrc ? BRANCH : SEQ);
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: debug-load, next-PC control and IF/ID output bundle of the fetch stage
interface if_stage_if;
  import if_pkg::*;
  logic                i_dunit_clk_en;
  logic                i_dunit_w_en;
  logic [NB_WIDHT-1:0] i_dunit_addr;
  logic [NB_REG-1:0]   i_dunit_data;
  logic                i_PCSrc;
  logic                i_Jump;
  logic                i_JSel;
  logic                i_PCWrite;
  logic [NB_REG-1:0]   i_inmed;
  logic [NB_INST-1:0]  i_inst_to_mxp;
  logic [NB_REG-1:0]   i_pc_jsel;
  logic [NB_REG-1:0]   o_pcplus4;
  logic [NB_REG-1:0]   o_instruction;
  modport master (
    output i_dunit_clk_en, i_dunit_w_en, i_dunit_addr, i_dunit_data,
    output i_PCSrc, i_Jump, i_JSel, i_PCWrite, i_inmed, i_inst_to_mxp, i_pc_jsel,
    input  o_pcplus4, o_instruction
  );
  modport slave (
    input  i_dunit_clk_en, i_dunit_w_en, i_dunit_addr, i_dunit_data,
    input  i_PCSrc, i_Jump, i_JSel, i_PCWrite, i_inmed, i_inst_to_mxp, i_pc_jsel,
    output o_pcplus4, o_instruction
  );
endinterface

// File: rtl/if_inst_mem.sv
// if_inst_mem: word memory, async read / sync write; IF_MEM_CLEAR_EN adds a reset clear
module if_inst_mem
  import if_pkg::*;
#(
  parameter int NB_DATA = NB_REG,
  parameter int NB_ADDR = NB_WIDHT - 2
) (
  input  logic               clk,
`ifdef IF_MEM_CLEAR_EN
  input  logic               rst,
`endif
  input  logic               w_en,
  input  logic [NB_ADDR-1:0] w_addr,
  input  logic [NB_DATA-1:0] w_data,
  input  logic [NB_ADDR-1:0] r_addr,
  output logic [NB_DATA-1:0] r_data
);
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  assign r_data = mem_q[r_addr];
`ifdef IF_MEM_CLEAR_EN
  always_ff @(posedge clk)
    if (rst) mem_q <= '{default: '0};
    else if (w_en) mem_q[w_addr] <= w_data;
`else
  always_ff @(posedge clk)
    if (w_en) mem_q[w_addr] <= w_data;
`endif
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage - PC register, next-PC mux and local instruction memory
// IF_MEM_CLEAR_EN: reset also zeroes the instruction memory
module if_stage
  import if_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  if_stage_if.slave     bus
);
  logic [NB_REG-1:0] pc_q, pc_d, pcplus4;
  pc_sel_e sel;
  logic unused_ok;
  always_comb begin
    pcplus4 = pc_q + NB_REG'(4);
    sel = pc_select(bus.i_Jump, bus.i_JSel, bus.i_PCSrc);
    pc_d = !(bus.i_dunit_clk_en && bus.i_PCWrite) ? pc_q :
           sel == JREG   ? bus.i_pc_jsel :
           sel == JUMP   ? {pcplus4[NB_REG-1:NB_REG-4], bus.i_inst_to_mxp, 2'b00} :
           sel == BRANCH ? bus.i_inmed : pcplus4;
  end
  always_ff @(posedge i_clk)
    pc_q <= i_reset ? '0 : pc_d;
  // memory is word addressed; byte-offset bits of the load address carry no data
  assign unused_ok = ^bus.i_dunit_addr[1:0];
  assign bus.o_pcplus4 = pcplus4;
  if_inst_mem #(.NB_DATA(NB_REG), .NB_ADDR(NB_WIDHT - 2)) u_mem (
    .clk    (i_clk),
`ifdef IF_MEM_CLEAR_EN
    .rst    (i_reset),
`endif
    .w_en   (bus.i_dunit_w_en),
    .w_addr (bus.i_dunit_addr[NB_WIDHT-1:2]),
    .w_data (bus.i_dunit_data),
    .r_addr (pc_q[NB_WIDHT-1:2]),
    .r_data (bus.o_instruction)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage (expected PC+4/instruction queued per edge)
module tb_if_stage;
  import if_pkg::*;
  typedef struct {
    string       tag;
    logic [31:0] pc4;
    logic [31:0] inst;
    bit          ci;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  if_stage_if bus();
  if_stage dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] mem_m [128];
  logic [31:0] pc_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit ci);
    logic [31:0] p4, npc;
    exp_t e;
    p4 = pc_m + 32'd4;
    npc = (bus.i_Jump && bus.i_JSel) ? bus.i_pc_jsel :
          bus.i_Jump ? {p4[31:28], bus.i_inst_to_mxp, 2'b00} :
          bus.i_PCSrc ? bus.i_inmed : p4;
    if (bus.i_dunit_w_en) mem_m[bus.i_dunit_addr[8:2]] = bus.i_dunit_data;
    if (rst) begin
      pc_m = 0;
`ifdef IF_MEM_CLEAR_EN
      mem_m = '{default: '0};
`endif
    end else if (bus.i_dunit_clk_en && bus.i_PCWrite) pc_m = npc;
    q.push_back('{tag, pc_m + 32'd4, mem_m[pc_m[8:2]], ci});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      check({e.tag, "_pc4"}, bus.o_pcplus4, e.pc4);
      if (e.ci) check({e.tag, "_inst"}, bus.o_instruction, e.inst);
    end
  endtask

  task automatic ctl(input logic pcsrc, input logic jump, input logic jsel,
                     input logic [31:0] inmed, input logic [25:0] mxp, input logic [31:0] jreg);
    bus.i_PCSrc = pcsrc;
    bus.i_Jump = jump;
    bus.i_JSel = jsel;
    bus.i_inmed = inmed;
    bus.i_inst_to_mxp = mxp;
    bus.i_pc_jsel = jreg;
  endtask

  task automatic wr(input logic [8:0] addr, input logic [31:0] data);
    bus.i_dunit_w_en = 1;
    bus.i_dunit_addr = addr;
    bus.i_dunit_data = data;
    step("wr", 1);
    bus.i_dunit_w_en = 0;
  endtask

  initial begin
    bus.i_dunit_clk_en = 1;
    bus.i_dunit_w_en = 0;
    bus.i_dunit_addr = 0;
    bus.i_dunit_data = 0;
    bus.i_PCWrite = 1;
    ctl(0, 0, 0, 0, 0, 0);
    step("reset", 0);
    check("reset_pc4", bus.o_pcplus4, 32'h4);
    rst = 0;
    bus.i_PCWrite = 0;
    for (int i = 0; i < 128; i++) wr(9'(i * 4), $urandom);
    wr(9'h08, 32'hDEADBEEF);
    wr(9'h0C, 32'h12345678);
    bus.i_PCWrite = 1;
    step("run1", 1);
    step("run2", 1);
    check("fetch_08", bus.o_instruction, 32'hDEADBEEF);
    step("run3", 1);
    check("fetch_0c", bus.o_instruction, 32'h12345678);
    rst = 1;
    step("rst2", 1);
    rst = 0;
    ctl(1, 0, 0, 32'h20, 0, 0);
    step("branch", 1);
    check("branch_pc4", bus.o_pcplus4, 32'h24);
    ctl(0, 1, 0, 0, 26'h2AAAAAA, 0);
    step("jimm", 1);
    check("jimm_pc4", bus.o_pcplus4, 32'h0AAAAAAC);
    ctl(0, 1, 1, 0, 26'h2AAAAAA, 32'h80);
    step("jreg", 1);
    check("jreg_pc4", bus.o_pcplus4, 32'h84);
    ctl(1, 1, 0, 32'h100, 26'h10, 32'h300);
    step("prio_j", 1);
    check("prio_j_pc4", bus.o_pcplus4, 32'h44);
    ctl(1, 1, 1, 32'h100, 26'h10, 32'h300);
    step("prio_jr", 1);
    check("prio_jr_pc4", bus.o_pcplus4, 32'h304);
    ctl(0, 0, 1, 32'h100, 26'h10, 32'h40);
    step("jsel_ign", 1);
    check("jsel_ign_pc4", bus.o_pcplus4, 32'h308);
    ctl(0, 1, 1, 0, 0, 32'h40);
    step("to40", 1);
    bus.i_PCWrite = 0;
    for (int i = 0; i < 3; i++) step("stall_pw", 1);
    check("stall_pw_pc4", bus.o_pcplus4, 32'h44);
    bus.i_PCWrite = 1;
    bus.i_dunit_clk_en = 0;
    for (int i = 0; i < 3; i++) step("stall_ce", 1);
    check("stall_ce_pc4", bus.o_pcplus4, 32'h44);
    check("pre_write", bus.o_instruction, mem_m[16]);
    wr(9'h40, 32'hCAFEF00D);
    check("write_cur", bus.o_instruction, 32'hCAFEF00D);
    bus.i_dunit_clk_en = 1;
    rst = 1;
    step("rst_mid", 1);
    check("rst_mid_pc4", bus.o_pcplus4, 32'h4);
    rst = 0;
    ctl(0, 1, 1, 0, 0, 32'hFFFFFFFC);
    step("to_top", 1);
    check("wrap_pc4", bus.o_pcplus4, 32'h0);
    ctl(0, 0, 0, 0, 0, 0);
    step("wrap_seq", 1);
    check("wrap_seq_pc4", bus.o_pcplus4, 32'h4);
    ctl(0, 1, 1, 0, 0, 32'h00000A0B);
    step("alias", 1);
    for (int i = 0; i < 60; i++) begin
      ctl(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 26'($urandom), $urandom);
      bus.i_PCWrite = ($urandom_range(0, 3) != 0);
      bus.i_dunit_clk_en = ($urandom_range(0, 3) != 0);
      bus.i_dunit_w_en = 1'($urandom);
      bus.i_dunit_addr = 9'($urandom);
      bus.i_dunit_data = $urandom;
      rst = ($urandom_range(0, 15) == 0);
      step("rand", 1);
    end
    rst = 0;
    bus.i_dunit_w_en = 0;
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
